spi_target: RTL
===============

// Module: spi_target
// PURPOSE
//  SPI target (slave) peripheral. Complements the SPI master and shares its bus register interface.
//  An external SPI master drives sck/cs_n/mosi. The block receives one byte per 8 sck cycles into
//  rx_data and shifts out a CPU-preloaded tx byte on miso. Memory-mapped on the valid/ready SoC bus.
//  Everything runs in the clk domain; the SPI pins are oversampled (f_clk >= 8 x f_sck).
// PARAMETERS
//  CPOL      0     sck idle level
//  CPHA      0     0: sample on leading edge, drive on trailing; 1: drive on leading, sample on trailing
//  SYNC_FF   2     synchronizer depth on sck/cs_n/mosi (>=2)
// PORTS
//  clk     in   1   system clock
//  reset   in   1   synchronous, active-high reset
//  valid   in   1   bus request
//  ready   out  1   bus acknowledge, 1-cycle pulse
//  addr    in   32  byte address; addr[3:2] selects register
//  wstrb   in   4   write strobes; 0 = read
//  wdata   in   32  write data
//  rdata   out  32  read data, valid while ready=1
//  sck     in   1   SPI clock from master (async)
//  cs_n    in   1   SPI chip select, active low (async)
//  mosi    in   1   SPI data in (async)
//  miso    out  1   SPI data out
//  miso_oe out  1   miso output enable (pad tristate); = !cs_n_sync
// BEHAVIOUR
//  Reset: ready=0, rdata=0, miso=0, miso_oe=0, rx_data=0, rx_valid=0, overrun=0, tx_full=0,
//   tx_hold=8'hFF, bit_cnt=0, state=IDLE. Reset mid-transfer aborts it; nothing is retained.
//  Sync: sck, cs_n, mosi pass SYNC_FF flops. Edges are detected on synced sck; leading edge = rising
//   if CPOL=0, else falling. Pin-to-internal latency is SYNC_FF+1 clk.
//  FSM: IDLE --cs_n_sync fall--> ACTIVE --cs_n_sync rise--> IDLE.
//   Entering ACTIVE: shreg <= (tx_full ? tx_hold : 8'hFF); tx_full <= 0; bit_cnt <= 0.
//   CPHA=0: miso = shreg[7] immediately. CPHA=1: first bit appears on the first leading edge.
//  Shifting is MSB first. On each sample edge: shreg <= {shreg[6:0], mosi_sync}; bit_cnt++.
//   On each drive edge: miso <= shreg[7].
//  Byte complete (8th sample):
//   - rx_data <= byte; rx_valid <= 1.
//   - If rx_valid was already 1: overrun <= 1 and rx_data is overwritten.
//   - bit_cnt <= 0; reload shreg from tx_hold (or 8'hFF if !tx_full); tx_full <= 0.
//  cs_n rise mid-byte: partial byte discarded, no rx_valid, bit_cnt <= 0.
//   An unconsumed tx_hold stays pending. miso <= 0.
//  Bus: ready <= valid & !ready, so an access completes one cycle after valid.
//   rdata registered in that same cycle; rdata = 0 when not ready.
//   addr[3:2]=0 DATA: read -> {24'b0, rx_data}, rx_valid <= 0.
//                     write (wstrb[0]) -> tx_hold <= wdata[7:0], tx_full <= 1.
//   addr[3:2]=1 STATUS: read -> {28'b0, busy, overrun, tx_full, rx_valid}; busy = (state==ACTIVE).
//                       write with wdata[2]=1 clears overrun.
//   Other offsets: read 0, writes ignored.
//  Simultaneous events:
//   - Byte complete + DATA read in same cycle: read returns old rx_data; rx_valid stays 1 with new byte.
//   - Reload + TX write in same cycle: reload takes old tx_hold; new value stored, tx_full=1.
//   - Byte complete + overrun clear in same cycle: set wins.
// CONFIGURATION
//  SPI_TARGET_IRQ_EN defined: adds port "irq out 1".
//   - irq = rx_valid | overrun, level-sensitive.
//   - STATUS bit4 = irq_mask (RW, reset 0); irq is gated by irq_mask.
//  Undefined: no irq port; STATUS bit4 reads 0 and writes are ignored.
// STRUCTURE
//  spi_target_pkg:
//   - state enum {IDLE, ACTIVE}.
//   - Register offsets REG_DATA=0, REG_STATUS=4.
//   - Status bit indices ST_RXV=0, ST_TXF=1, ST_OVR=2, ST_BUSY=3, ST_IRQM=4.
//   - Idle fill byte FILL_BYTE=8'hFF.
//  Sub-module spi_target_sync: SYNC_FF-deep synchronizer plus edge detect.
//   Instantiated once per pin; provides rise/fall pulses.
// TESTING
//  1 Mode 0: write DATA=0xA5, master sends 0x3C at f_clk/16
//     -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1, tx_full=0.
//  2 Modes 1/2/3: same exchange with 0x96/0x69 -> correct bytes both directions in every mode.
//  3 Two bytes in one cs_n frame, no DATA read between
//     -> overrun=1, rx_data=second byte; write STATUS 0x4 -> overrun=0.
//  4 No tx preload: master clocks 8 bits -> miso shifts 0xFF; tx_full stays 0.
//  5 cs_n raised after 5 bits of 0xF0 -> rx_valid=0; next full frame 0x11 -> rx_data=0x11, bit alignment correct.
//  6 reset asserted mid-byte -> all status 0, miso_oe=0, next frame received correctly;
//     with SPI_TARGET_IRQ_EN, mask=1 -> irq rises with rx_valid.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target peripheral.
package spi_target_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;

  localparam int ST_RXV  = 0;
  localparam int ST_TXF  = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_BUSY = 3;
  localparam int ST_IRQM = 4;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // Index of each SPI pin in the synchronizer array
  localparam int PIN_SCK  = 0;
  localparam int PIN_CS   = 1;
  localparam int PIN_MOSI = 2;
  localparam int NUM_PINS = 3;

  function automatic logic [7:0] next_tx(input logic full, input logic [7:0] hold);
    return full ? hold : FILL_BYTE;
  endfunction

endpackage

// File: rtl/spi_target_if.sv
// Valid/ready register bus between the SoC and the SPI target.
interface spi_target_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, addr, wstrb, wdata, input ready, rdata);
  modport slave  (input valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/spi_target_sync.sv
// SYNC_FF-deep pin synchronizer with rise/fall pulses; reset value matches the pin's idle level.
module spi_target_sync #(
  parameter int SYNC_FF = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_FF-1:0] r_sync;
  logic               r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_FF{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_FF-2:0], i_pin};
      r_prev <= r_sync[SYNC_FF-1];
    end
  end

  assign o_sync = r_sync[SYNC_FF-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_target.sv
// SPI target: oversampled SPI pins, one rx/tx byte buffer, valid/ready register bus.
// Optional SPI_TARGET_IRQ_EN adds a maskable level interrupt output.
module spi_target
  import spi_target_pkg::*;
#(
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0,
  parameter int SYNC_FF = 2
) (
  input  logic         clk,
  input  logic         reset,
  spi_target_if.slave  bus,
  input  logic         sck,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe
`ifdef SPI_TARGET_IRQ_EN
  ,
  output logic         irq
`endif
);

  logic [NUM_PINS-1:0] w_pin, w_sync, w_rise, w_fall;

  assign w_pin = {mosi, cs_n, sck};

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_sync
    spi_target_sync #(
      .SYNC_FF (SYNC_FF),
      .RST_VAL ((i == PIN_CS) || ((i == PIN_SCK) && CPOL))
    ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .i_pin  (w_pin[i]),
      .o_sync (w_sync[i]),
      .o_rise (w_rise[i]),
      .o_fall (w_fall[i])
    );
  end

  state_e      r_state;
  logic [7:0]  r_shreg, r_rx_data, r_tx_hold;
  logic [2:0]  r_bit_cnt;
  logic        r_rx_valid, r_overrun, r_tx_full, r_miso;
  logic        r_ready;
  logic [31:0] r_rdata;
`ifdef SPI_TARGET_IRQ_EN
  logic        r_irq_mask;
`endif

  logic        w_lead, w_trail, w_sample, w_drive;
  logic        w_acc, w_rd, w_wr;
  logic [3:0]  w_off;
  logic [7:0]  w_load, w_shift;
  logic [31:0] w_rdata;

  assign w_lead   = CPOL ? w_fall[PIN_SCK] : w_rise[PIN_SCK];
  assign w_trail  = CPOL ? w_rise[PIN_SCK] : w_fall[PIN_SCK];
  assign w_sample = CPHA ? w_trail : w_lead;
  assign w_drive  = CPHA ? w_lead  : w_trail;

  assign w_load  = next_tx(r_tx_full, r_tx_hold);
  assign w_shift = {r_shreg[6:0], w_sync[PIN_MOSI]};

  assign w_off = {bus.addr[3:2], 2'b00};
  assign w_acc = bus.valid & ~r_ready;
  assign w_rd  = w_acc & (bus.wstrb == 4'h0);
  assign w_wr  = w_acc & bus.wstrb[0];

  always_comb begin
    w_rdata = '0;
    case (w_off)
      REG_DATA:   w_rdata[7:0] = r_rx_data;
      REG_STATUS: begin
        w_rdata[ST_RXV]  = r_rx_valid;
        w_rdata[ST_TXF]  = r_tx_full;
        w_rdata[ST_OVR]  = r_overrun;
        w_rdata[ST_BUSY] = (r_state == ACTIVE);
`ifdef SPI_TARGET_IRQ_EN
        w_rdata[ST_IRQM] = r_irq_mask;
`endif
      end
      default: ;
    endcase
  end

  // Bus clears come before SPI events and the TX write comes after, so that
  // byte-complete sets win over reads/clears and a same-cycle TX write survives a reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_rx_data  <= '0;
      r_tx_hold  <= FILL_BYTE;
      r_bit_cnt  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_tx_full  <= 1'b0;
      r_miso     <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
`ifdef SPI_TARGET_IRQ_EN
      r_irq_mask <= 1'b0;
`endif
    end else begin
      r_ready <= bus.valid & ~r_ready;
      r_rdata <= '0;
      if (w_rd) begin
        r_rdata <= w_rdata;
        if (w_off == REG_DATA) r_rx_valid <= 1'b0;
      end
      if (w_wr && w_off == REG_STATUS) begin
        if (bus.wdata[ST_OVR]) r_overrun <= 1'b0;
`ifdef SPI_TARGET_IRQ_EN
        r_irq_mask <= bus.wdata[ST_IRQM];
`endif
      end

      case (r_state)
        IDLE: begin
          if (w_fall[PIN_CS]) begin
            r_state   <= ACTIVE;
            r_shreg   <= w_load;
            r_tx_full <= 1'b0;
            r_bit_cnt <= '0;
            if (!CPHA) r_miso <= w_load[7];
          end
        end
        ACTIVE: begin
          if (w_rise[PIN_CS]) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
          end else begin
            if (w_sample) begin
              if (r_bit_cnt == 3'd7) begin
                r_rx_data  <= w_shift;
                r_rx_valid <= 1'b1;
                if (r_rx_valid) r_overrun <= 1'b1;
                r_bit_cnt  <= '0;
                r_shreg    <= w_load;
                r_tx_full  <= 1'b0;
              end else begin
                r_shreg   <= w_shift;
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
            if (w_drive) r_miso <= r_shreg[7];
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_wr && w_off == REG_DATA) begin
        r_tx_hold <= bus.wdata[7:0];
        r_tx_full <= 1'b1;
      end
    end
  end

  assign bus.ready = r_ready;
  assign bus.rdata = r_rdata;
  assign miso      = r_miso;
  assign miso_oe   = ~w_sync[PIN_CS];

`ifdef SPI_TARGET_IRQ_EN
  assign irq = r_irq_mask & (r_rx_valid | r_overrun);
`endif

  logic w_unused;
  assign w_unused = ^{w_sync[PIN_SCK], w_rise[PIN_MOSI], w_fall[PIN_MOSI],
                      bus.addr[31:4], bus.addr[1:0], bus.wdata[31:8], bus.wstrb[3:1]};

endmodule
